// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receiver with run-time divisor, valid/ack handshake, framing and overrun flags
module uart_receiver #(
    parameter int DATA_W   = 8,
    parameter int COMP_MIN = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [15:0]       comp,
    input  logic              rec_en,
    input  logic              uart_rx,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ack,
    output logic              frame_err,
    output logic              overrun_err
);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    state_t            r_state, w_state_nx;
    logic [1:0]        r_sync;
    logic [15:0]       r_comp, r_cnt, w_cnt_nx, w_limit;
    logic [2:0]        r_idx, w_idx_nx;
    logic [DATA_W-1:0] r_shift, w_shift_nx;
    logic              w_rxs, w_tick, w_done, w_ferr, w_latch, w_ack;

    assign w_rxs   = r_sync[1];
    assign w_limit = (r_state == START) ? {1'b0, r_comp[15:1]} : r_comp;
    assign w_tick  = (r_cnt == w_limit - 16'd1);
    assign w_ack   = rx_ack & rx_valid;

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = w_tick ? '0 : r_cnt + 16'd1;
        w_idx_nx   = r_idx;
        w_shift_nx = r_shift;
        w_done     = 1'b0;
        w_ferr     = 1'b0;
        w_latch    = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nx = '0;
                if (rec_en && !w_rxs) begin
                    w_latch    = 1'b1;
                    w_state_nx = START;
                end
            end
            START: if (w_tick) begin
                w_state_nx = w_rxs ? IDLE : DATA;
                w_idx_nx   = '0;
            end
            DATA: if (w_tick) begin
                w_shift_nx = {w_rxs, r_shift[DATA_W-1:1]};
                w_idx_nx   = r_idx + 3'd1;
                if (r_idx == 3'(DATA_W - 1)) w_state_nx = STOP;
            end
            STOP: if (w_tick) begin
                w_done     = w_rxs;
                w_ferr     = !w_rxs;
                w_state_nx = w_rxs ? IDLE : BRK;
            end
            BRK: if (w_rxs) w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
        // disabling mid-frame drops the frame silently
        if (r_state != IDLE && !rec_en) begin
            w_state_nx = IDLE;
            w_done     = 1'b0;
            w_ferr     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_sync      <= 2'b11;
            r_state     <= IDLE;
            r_comp      <= '0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            r_sync      <= {r_sync[0], uart_rx};
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_idx       <= w_idx_nx;
            r_shift     <= w_shift_nx;
            // clamp illegal divisors so the timer always terminates
            if (w_latch) r_comp <= (comp < 16'(COMP_MIN)) ? 16'(COMP_MIN) : comp;
            if (w_done) rx_data <= r_shift;
            frame_err   <= w_ferr;
            rx_valid    <= w_done | (rx_valid & ~w_ack);
            overrun_err <= (w_done & rx_valid & ~w_ack) | (overrun_err & ~w_ack);
        end
    end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: randomized and directed checks of uart_receiver against a sample-time reference model
module tb_uart_receiver;
    logic        clk = 0, resetn = 1, rec_en = 1, uart_rx = 1, rx_ack = 0;
    logic [15:0] comp = 16'd434;
    logic [7:0]  rx_data;
    logic        rx_valid, frame_err, overrun_err;
    int          vectors = 0, miscompares = 0, cyc = 0, ack_at = -1, ferr_cnt = 0;
    bit          auto_ack = 1;

    int          m_mode = 0, m_d = 0, m_c = 4, m_t;
    logic        m_p1 = 1, m_p2 = 1, m_rxs, m_ack, m_done;
    logic [7:0]  m_bits = 0, m_data = 0;
    logic        m_valid = 0, m_ferr = 0, m_ovr = 0;

    uart_receiver #(.DATA_W(8), .COMP_MIN(4)) dut (
        .clk(clk), .resetn(resetn), .comp(comp), .rec_en(rec_en), .uart_rx(uart_rx),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
        .frame_err(frame_err), .overrun_err(overrun_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", n, a, e, cyc);
        end
    endtask

    // Reference: line seen two edges late; sample instants from the absolute start time D.
    always @(posedge clk) begin
        cyc++;
        if (resetn) begin
            m_mode = 0; m_p1 = 1; m_p2 = 1;
            m_valid = 0; m_data = 0; m_ferr = 0; m_ovr = 0;
        end else begin
            m_rxs = m_p2; m_p2 = m_p1; m_p1 = uart_rx;
            m_ack = rx_ack && m_valid; m_done = 0; m_ferr = 0;
            if (m_mode == 0) begin
                if (rec_en && !m_rxs) begin m_d = cyc; m_c = int'(comp); m_mode = 1; end
            end else if (!rec_en) m_mode = 0;
            else if (m_mode == 2) begin
                if (m_rxs) m_mode = 0;
            end else begin
                m_t = cyc - m_d - m_c / 2;
                if (m_t == 0) begin
                    if (m_rxs) m_mode = 0;
                end else if (m_t > 0 && m_t % m_c == 0) begin
                    if (m_t / m_c <= 8) m_bits[m_t / m_c - 1] = m_rxs;
                    else begin m_done = m_rxs; m_ferr = !m_rxs; m_mode = m_rxs ? 0 : 2; end
                end
            end
            if (m_done) begin
                m_ovr = (m_ovr || m_valid) && !m_ack;
                m_valid = 1; m_data = m_bits;
            end else if (m_ack) begin
                m_valid = 0; m_ovr = 0;
            end
        end
    end

    always @(negedge clk) begin
        check("rx_valid", 32'(rx_valid), resetn ? 32'd0 : 32'(m_valid));
        check("rx_data", 32'(rx_data), resetn ? 32'd0 : 32'(m_data));
        check("frame_err", 32'(frame_err), resetn ? 32'd0 : 32'(m_ferr));
        check("overrun_err", 32'(overrun_err), resetn ? 32'd0 : 32'(m_ovr));
        if (frame_err) ferr_cnt++;
    end

    always @(negedge clk) rx_ack = (auto_ack && rx_valid && !rx_ack) || (ack_at == cyc + 1);

    task automatic drive(input logic v, input int n);
        uart_rx = v;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [7:0] b, input int c, input logic stop);
        comp = 16'(c);
        drive(1'b0, c);
        comp = 16'($urandom);
        for (int i = 0; i < 8; i++) drive(b[i], c);
        drive(stop, c);
    endtask

    task automatic wait_valid(output int t, input int budget);
        t = -1;
        for (int i = 0; i < budget && t < 0; i++) begin
            @(negedge clk);
            if (rx_valid) t = cyc;
        end
        if (t < 0) check("wait_valid_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_ack();
        ack_at = cyc + 1;
        drive(1'b1, 3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: cycle %0d exceeded limit", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] lb [4] = '{8'hA5, 8'h00, 8'hFF, 8'h3C};
        int cs [8] = '{4, 5, 7, 8, 13, 16, 24, 31};
        int t0, t, f0, c;
        repeat (3) @(posedge clk);
        #1 resetn = 0;
        @(negedge clk);
        check("reset_valid", 32'(rx_valid), 32'd0);
        check("reset_data", 32'(rx_data), 32'd0);
        check("reset_ferr", 32'(frame_err), 32'd0);
        check("reset_ovr", 32'(overrun_err), 32'd0);
        @(posedge clk); #1;

        t0 = cyc;
        fork
            for (int k = 0; k < 4; k++) send(lb[k], 434, 1'b1);
            for (int k = 0; k < 4; k++) begin
                wait_valid(t, 6000);
                check("lb_data", 32'(rx_data), 32'(lb[k]));
                check("lb_latency", 32'(t - t0 - k * 4340), 32'd4126);
                @(negedge clk);
            end
        join
        drive(1'b1, 300);
        auto_ack = 0;

        f0 = ferr_cnt; comp = 16'd434;
        drive(1'b0, 108);
        drive(1'b1, 900);
        check("glitch_valid", 32'(rx_valid), 32'd0);
        check("glitch_ferr", 32'(ferr_cnt - f0), 32'd0);

        f0 = ferr_cnt;
        send(8'h55, 20, 1'b0);
        drive(1'b0, 60);
        drive(1'b1, 20);
        check("frame_pulses", 32'(ferr_cnt - f0), 32'd1);
        check("frame_valid", 32'(rx_valid), 32'd0);
        send(8'h12, 20, 1'b1);
        drive(1'b1, 20);
        check("after_break_valid", 32'(rx_valid), 32'd1);
        check("after_break_data", 32'(rx_data), 32'h12);
        do_ack();

        send(8'h11, 20, 1'b1);
        drive(1'b1, 10);
        send(8'h22, 20, 1'b1);
        drive(1'b1, 20);
        check("ovr_data", 32'(rx_data), 32'h22);
        check("ovr_valid", 32'(rx_valid), 32'd1);
        check("ovr_flag", 32'(overrun_err), 32'd1);
        do_ack();
        check("ovr_ack_valid", 32'(rx_valid), 32'd0);
        check("ovr_ack_flag", 32'(overrun_err), 32'd0);
        send(8'h33, 20, 1'b1);
        drive(1'b1, 10);
        t0 = cyc;
        ack_at = t0 + 3 + 10 + 180;
        send(8'h44, 20, 1'b1);
        drive(1'b1, 20);
        check("coinc_data", 32'(rx_data), 32'h44);
        check("coinc_valid", 32'(rx_valid), 32'd1);
        check("coinc_ovr", 32'(overrun_err), 32'd0);
        do_ack();

        fork
            send(8'h5A, 20, 1'b1);
            begin repeat (110) @(posedge clk); #1 rec_en = 0; end
        join
        drive(1'b1, 20);
        rec_en = 1;
        check("abort_valid", 32'(rx_valid), 32'd0);

        fork
            send(8'h66, 20, 1'b1);
            begin repeat (60) @(posedge clk); #1 resetn = 1; end
        join
        drive(1'b1, 5);
        resetn = 0;
        @(negedge clk);
        check("rst2_valid", 32'(rx_valid), 32'd0);
        check("rst2_data", 32'(rx_data), 32'd0);
        check("rst2_ovr", 32'(overrun_err), 32'd0);
        @(posedge clk); #1;
        send(8'h7E, 20, 1'b1);
        drive(1'b1, 20);
        check("post_rst_data", 32'(rx_data), 32'h7E);
        check("post_rst_valid", 32'(rx_valid), 32'd1);
        do_ack();

        auto_ack = 1;
        for (int n = 0; n < 120; n++) begin
            c = cs[$urandom_range(0, 7)];
            send(8'($urandom), c, $urandom_range(0, 9) != 0);
            drive(1'b1, $urandom_range(0, 2 * c));
        end
        drive(1'b1, 40);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
